fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register for the 5-stage pipelined ARM core. It sits directly upstream of the decode/control logic and supplies InstrD (Cond/Instr fields) to it. It consumes BranchTakenE/ALUResultE and PCSrcW/ResultW from the controller/datapath, plus stall/flush from the hazard unit. The PC register, next-PC selection and a req/ack handshake to a variable-latency instruction memory all live here.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, word driven on InstrD when decode holds a bubble.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  synchronous, active-low reset.
StallF  input  1  hazard unit: hold PC / fetch.
StallD  input  1  hazard unit: hold IF/ID register.
FlushD  input  1  hazard unit: load bubble into IF/ID.
BranchTakenE  input  1  branch resolved taken in Execute.
ALUResultE  input  32  branch target from Execute.
PCSrcW  input  1  PC write from Writeback.
ResultW  input  32  Writeback PC value.
ImemReq  output  1  fetch request to instruction memory.
ImemAddr  output  32  fetch address (= PCF).
ImemAck  input  1  memory returns ImemRData this cycle; may arrive in the same cycle as ImemReq.
ImemRData  input  32  fetched instruction word.
PCF  output  32  current fetch PC.
InstrD  output  32  instruction in Decode.
ValidD  output  1  InstrD holds a real instruction.
PCPlus8D  output  32  PC of the Decode instruction + 8.
FetchBusy  output  1  fetch cannot supply an instruction this cycle.

Behaviour:
- Reset (reset==0 at posedge):
  - PCF=RESET_PC, state=IDLE, InstrD=NOP_INSTR, ValidD=0, PCPlus8D=RESET_PC+8.
  - Redirect-pending flag cleared; hold buffer cleared.
  - Reset asserted mid-transaction abandons it; an ImemAck arriving in the cycle reset deasserts is ignored in IDLE.
- Effective stall: stall = StallF | StallD.
- Redirect:
  - redir = BranchTakenE | PCSrcW.
  - Target = BranchTakenE ? ALUResultE : ResultW; BranchTakenE has priority.
  - PCPlus4F = PCF+4, 32-bit wrap-around, no overflow flag.
- FSM:
  - IDLE: ImemReq=0, FetchBusy=1. Go to FETCH next cycle unconditionally.
  - FETCH: ImemReq=1, ImemAddr=PCF; address must stay stable until ImemAck.
    - ImemAck & !pending & !redir & !stall: PCF<=PCPlus4F; word delivered to IF/ID; stay FETCH. Zero-wait memory gives 1 instr/cycle.
    - ImemAck & !pending & !redir & stall: word goes to hold buffer (with its PC); PCF unchanged; go HOLD.
    - ImemAck & (pending | redir): word discarded. PCF<=(redir ? current Target : pending target). Pending cleared. IF/ID gets bubble unless StallD. Stay FETCH.
    - !ImemAck & redir: record pending target (a later redirect overwrites it); PCF unchanged; FetchBusy=1.
    - !ImemAck & !redir: FetchBusy=1.
  - HOLD: ImemReq=0, FetchBusy=0.
    - redir: drop held word; PCF<=Target; go FETCH.
    - !stall: held word delivered to IF/ID; PCF<=PCF+4; go FETCH.
    - else: stay HOLD.
- IF/ID register, priority FlushD > StallD > load:
  - FlushD: InstrD=NOP_INSTR, ValidD=0.
  - StallD: hold all fields.
  - Load with a word available: InstrD=word, ValidD=1, PCPlus8D=word PC+8.
  - Load with no word available: InstrD=NOP_INSTR, ValidD=0.
- Redirect overrides StallF for PC update; the hazard unit never asserts both together, but the RTL must still honour redirect.
- StallD without StallF behaves as a full stall; no instruction is lost or duplicated.

Test Plan:
- Reset low 2 cycles, then high, zero-wait memory (ImemAck=ImemReq) -> IDLE 1 cycle; PCF 0,4,8,12 on consecutive cycles; InstrD follows mem[0],mem[4]… one cycle later; ValidD=1; PCPlus8D=8,12,….
- Memory with 2 wait cycles -> ImemReq held with ImemAddr=0 until ack; FetchBusy=1 during wait; ValidD=0 bubbles inserted; one instruction per 3 cycles.
- Ack arrives while StallF=StallD=1 for 3 cycles -> word kept in HOLD; InstrD unchanged; after release, that word appears exactly once and PCF advances by 4.
- BranchTakenE=1, ALUResultE=0x100 while waiting for ack at PC=0x20 -> returned word discarded; next ImemAddr=0x100; no ValidD=1 for 0x20.
- BranchTakenE=1 (0x200) and PCSrcW=1 (0x300) in the same cycle -> next PCF=0x200.
- FlushD=1 and StallD=1 together -> InstrD=NOP_INSTR, ValidD=0; reset pulsed mid-fetch -> PCF=RESET_PC, ImemReq=0 next cycle.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Owns the PC, the next-PC selection and a req/ack handshake with a
// variable-latency instruction memory. A fetched word that cannot enter
// Decode because of a stall is parked in a one-entry hold buffer. A redirect
// that arrives while a fetch is in flight is remembered until the
// outstanding word returns, and that word is then thrown away.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        BranchTakenE,
  input  logic [31:0] ALUResultE,
  input  logic        PCSrcW,
  input  logic [31:0] ResultW,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemRData,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic        ValidD,
  output logic [31:0] PCPlus8D,
  output logic        FetchBusy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // PC and in-flight redirect bookkeeping
  logic [31:0] r_pcf;
  logic        r_pend;
  logic [31:0] r_pend_tgt;

  // One-entry buffer for a word that returned while the pipe was stalled
  logic        r_hold_vld;
  logic [31:0] r_hold_instr;
  logic [31:0] r_hold_pc;

  // IF/ID pipeline register
  logic [31:0] r_instr_d;
  logic        r_valid_d;
  logic [31:0] r_pc8_d;

  // Shared combinational terms
  logic        w_stall;
  logic        w_redir;
  logic [31:0] w_target;
  logic [31:0] w_pcplus4;

  // Per-cycle decisions produced by the FSM
  logic        w_pc_ld;
  logic [31:0] w_pc_val;
  logic        w_pend_set;
  logic        w_pend_clr;
  logic        w_hold_ld;
  logic        w_hold_clr;
  logic        w_word_vld;
  logic [31:0] w_word;
  logic [31:0] w_word_pc;
  logic        w_req;
  logic        w_busy;

  // A Decode-only stall must still freeze fetch, otherwise a word would be
  // pushed past a Decode stage that cannot accept it.
  assign w_stall   = StallF | StallD;
  assign w_redir   = BranchTakenE | PCSrcW;
  assign w_target  = BranchTakenE ? ALUResultE : ResultW;
  assign w_pcplus4 = r_pcf + 32'd4;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, handshake outputs and datapath steering
  always_comb begin
    w_state_nxt = r_state;
    w_pc_ld     = 1'b0;
    w_pc_val    = r_pcf;
    w_pend_set  = 1'b0;
    w_pend_clr  = 1'b0;
    w_hold_ld   = 1'b0;
    w_hold_clr  = 1'b0;
    w_word_vld  = 1'b0;
    w_word      = ImemRData;
    w_word_pc   = r_pcf;
    w_req       = 1'b0;
    w_busy      = 1'b1;

    case (r_state)
      S_IDLE: begin
        // Nothing is in flight yet, so a redirect can be applied directly.
        w_state_nxt = S_FETCH;
        if (w_redir) begin
          w_pc_ld  = 1'b1;
          w_pc_val = w_target;
        end
      end

      S_FETCH: begin
        w_req = 1'b1;
        if (ImemAck) begin
          if (r_pend || w_redir) begin
            // Returned word belongs to the wrong path; a redirect seen this
            // cycle is newer than any pending one and wins.
            w_pc_ld    = 1'b1;
            w_pc_val   = w_redir ? w_target : r_pend_tgt;
            w_pend_clr = 1'b1;
          end else if (!w_stall) begin
            w_busy     = 1'b0;
            w_word_vld = 1'b1;
            w_word     = ImemRData;
            w_word_pc  = r_pcf;
            w_pc_ld    = 1'b1;
            w_pc_val   = w_pcplus4;
          end else begin
            // Memory delivered but the pipe is frozen: park the word and
            // keep PCF pointing at it.
            w_busy      = 1'b0;
            w_hold_ld   = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end else if (w_redir) begin
          // The address must stay stable until the ack, so remember the
          // redirect and apply it when the stale word comes back.
          w_pend_set = 1'b1;
        end
      end

      S_HOLD: begin
        w_busy = 1'b0;
        if (w_redir) begin
          w_pc_ld     = 1'b1;
          w_pc_val    = w_target;
          w_hold_clr  = 1'b1;
          w_state_nxt = S_FETCH;
        end else if (!w_stall) begin
          w_word_vld  = 1'b1;
          w_word      = r_hold_instr;
          w_word_pc   = r_hold_pc;
          w_pc_ld     = 1'b1;
          w_pc_val    = w_pcplus4;
          w_hold_clr  = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Program counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pcf <= RESET_PC;
    end else if (w_pc_ld) begin
      r_pcf <= w_pc_val;
    end
  end

  // Pending redirect: later redirects overwrite the recorded target
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pend     <= 1'b0;
      r_pend_tgt <= RESET_PC;
    end else if (w_pend_clr) begin
      r_pend     <= 1'b0;
    end else if (w_pend_set) begin
      r_pend     <= 1'b1;
      r_pend_tgt <= w_target;
    end
  end

  // Hold buffer capturing a word returned during a stall
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hold_vld   <= 1'b0;
      r_hold_instr <= NOP_INSTR;
      r_hold_pc    <= RESET_PC;
    end else if (w_hold_ld) begin
      r_hold_vld   <= 1'b1;
      r_hold_instr <= ImemRData;
      r_hold_pc    <= r_pcf;
    end else if (w_hold_clr) begin
      r_hold_vld   <= 1'b0;
    end
  end

  // IF/ID register: flush beats stall beats load
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_instr_d <= NOP_INSTR;
      r_valid_d <= 1'b0;
      r_pc8_d   <= RESET_PC + 32'd8;
    end else if (FlushD) begin
      r_instr_d <= NOP_INSTR;
      r_valid_d <= 1'b0;
    end else if (StallD) begin
      r_instr_d <= r_instr_d;
      r_valid_d <= r_valid_d;
      r_pc8_d   <= r_pc8_d;
    end else if (w_word_vld) begin
      r_instr_d <= w_word;
      r_valid_d <= 1'b1;
      r_pc8_d   <= w_word_pc + 32'd8;
    end else begin
      r_instr_d <= NOP_INSTR;
      r_valid_d <= 1'b0;
    end
  end

  assign ImemReq   = w_req;
  assign ImemAddr  = r_pcf;
  assign PCF       = r_pcf;
  assign InstrD    = r_instr_d;
  assign ValidD    = r_valid_d;
  assign PCPlus8D  = r_pc8_d;
  assign FetchBusy = w_busy;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a simple wait-state memory model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        BranchTakenE;
  logic [31:0] ALUResultE;
  logic        PCSrcW;
  logic [31:0] ResultW;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemRData;
  logic [31:0] PCF;
  logic [31:0] InstrD;
  logic        ValidD;
  logic [31:0] PCPlus8D;
  logic        FetchBusy;

  int n_chk = 0;
  int n_bad = 0;
  int wait_n = 0;
  int cnt = 0;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .StallF      (StallF),
    .StallD      (StallD),
    .FlushD      (FlushD),
    .BranchTakenE(BranchTakenE),
    .ALUResultE  (ALUResultE),
    .PCSrcW      (PCSrcW),
    .ResultW     (ResultW),
    .ImemReq     (ImemReq),
    .ImemAddr    (ImemAddr),
    .ImemAck     (ImemAck),
    .ImemRData   (ImemRData),
    .PCF         (PCF),
    .InstrD      (InstrD),
    .ValidD      (ValidD),
    .PCPlus8D    (PCPlus8D),
    .FetchBusy   (FetchBusy)
  );

  always #5 clk = ~clk;

  // Memory: acks after wait_n cycles of continuous request; word = E1A0_<addr>
  always @(posedge clk) begin
    if (!ImemReq || ImemAck) cnt <= 0;
    else                     cnt <= cnt + 1;
  end
  assign ImemAck   = ImemReq && (cnt >= wait_n);
  assign ImemRData = {16'hE1A0, ImemAddr[15:0]};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    BranchTakenE = 1'b0; ALUResultE = 32'h0; PCSrcW = 1'b0; ResultW = 32'h0;

    // Reset state and IDLE cycle
    tick();
    tick();
    chk("rst_pcf",   PCF, 32'h0);
    chk("rst_valid", 32'(ValidD), 32'h0);
    chk("rst_instr", InstrD, 32'h0);
    chk("rst_pc8",   PCPlus8D, 32'h8);
    chk("rst_req",   32'(ImemReq), 32'h0);
    reset = 1'b1;
    #1;
    chk("idle_req",  32'(ImemReq), 32'h0);
    chk("idle_busy", 32'(FetchBusy), 32'h1);

    // Zero-wait streaming
    tick();
    chk("z_req",    32'(ImemReq), 32'h1);
    chk("z_addr0",  ImemAddr, 32'h0);
    chk("z_valid0", 32'(ValidD), 32'h0);
    tick();
    chk("z_pcf4",   PCF, 32'h4);
    chk("z_ins0",   InstrD, 32'hE1A0_0000);
    chk("z_vld0",   32'(ValidD), 32'h1);
    chk("z_pc8_0",  PCPlus8D, 32'h8);
    tick();
    chk("z_pcf8",   PCF, 32'h8);
    chk("z_ins4",   InstrD, 32'hE1A0_0004);
    chk("z_pc8_4",  PCPlus8D, 32'hC);
    tick();
    chk("z_pcfc",   PCF, 32'hC);
    chk("z_ins8",   InstrD, 32'hE1A0_0008);
    chk("z_pc8_8",  PCPlus8D, 32'h10);

    // Two wait cycles
    wait_n = 2;
    do_reset();
    chk("w_req",    32'(ImemReq), 32'h1);
    chk("w_addr_a", ImemAddr, 32'h0);
    chk("w_busy_a", 32'(FetchBusy), 32'h1);
    tick();
    chk("w_addr_b", ImemAddr, 32'h0);
    chk("w_busy_b", 32'(FetchBusy), 32'h1);
    chk("w_vld_b",  32'(ValidD), 32'h0);
    tick();
    chk("w_ackcyc", 32'(FetchBusy), 32'h0);
    chk("w_pcf_c",  PCF, 32'h0);
    tick();
    chk("w_pcf4",   PCF, 32'h4);
    chk("w_ins0",   InstrD, 32'hE1A0_0000);
    chk("w_vld0",   32'(ValidD), 32'h1);
    tick();
    chk("w_bubble", 32'(ValidD), 32'h0);
    tick();
    tick();
    chk("w_pcf8",   PCF, 32'h8);
    chk("w_ins4",   InstrD, 32'hE1A0_0004);
    chk("w_vld4",   32'(ValidD), 32'h1);

    // Ack during a full stall goes to the hold buffer
    wait_n = 0;
    do_reset();
    tick();
    StallF = 1'b1; StallD = 1'b1;
    tick();
    chk("h_req",    32'(ImemReq), 32'h0);
    chk("h_pcf",    PCF, 32'h4);
    chk("h_ins_a",  InstrD, 32'hE1A0_0000);
    tick();
    tick();
    chk("h_ins_b",  InstrD, 32'hE1A0_0000);
    chk("h_busy",   32'(FetchBusy), 32'h0);
    StallF = 1'b0; StallD = 1'b0;
    tick();
    chk("h_rel_ins", InstrD, 32'hE1A0_0004);
    chk("h_rel_vld", 32'(ValidD), 32'h1);
    chk("h_rel_pcf", PCF, 32'h8);
    chk("h_rel_pc8", PCPlus8D, 32'hC);
    tick();
    chk("h_next_ins", InstrD, 32'hE1A0_0008);
    chk("h_next_pcf", PCF, 32'hC);

    // Branch while waiting for ack at 0x20
    do_reset();
    repeat (8) tick();
    chk("b_pcf20", PCF, 32'h20);
    wait_n = 2;
    BranchTakenE = 1'b1; ALUResultE = 32'h100;
    tick();
    BranchTakenE = 1'b0; ALUResultE = 32'h0;
    chk("b_addr_hold", ImemAddr, 32'h20);
    chk("b_vld_a",     32'(ValidD), 32'h0);
    tick();
    chk("b_vld_b",     32'(ValidD), 32'h0);
    chk("b_addr_ack",  ImemAddr, 32'h20);
    tick();
    chk("b_pcf100",    PCF, 32'h100);
    chk("b_addr100",   ImemAddr, 32'h100);
    chk("b_vld_c",     32'(ValidD), 32'h0);
    wait_n = 0;
    tick();
    chk("b_ins100",    InstrD, 32'hE1A0_0100);
    chk("b_vld100",    32'(ValidD), 32'h1);
    chk("b_pc8_100",   PCPlus8D, 32'h108);

    // Branch and writeback redirect together: branch wins
    BranchTakenE = 1'b1; ALUResultE = 32'h200;
    PCSrcW = 1'b1; ResultW = 32'h300;
    tick();
    BranchTakenE = 1'b0; PCSrcW = 1'b0; ALUResultE = 32'h0; ResultW = 32'h0;
    chk("p_pcf200", PCF, 32'h200);
    chk("p_vld",    32'(ValidD), 32'h0);

    // FlushD with StallD
    tick();
    chk("f_ins200", InstrD, 32'hE1A0_0200);
    FlushD = 1'b1; StallD = 1'b1;
    tick();
    chk("f_ins_nop", InstrD, 32'h0);
    chk("f_vld",     32'(ValidD), 32'h0);
    FlushD = 1'b0; StallD = 1'b0;
    tick();
    chk("f_ins204", InstrD, 32'hE1A0_0204);
    chk("f_vld204", 32'(ValidD), 32'h1);
    chk("f_pcf208", PCF, 32'h208);
    chk("f_pc8",    PCPlus8D, 32'h20C);

    // Reset in the middle of a waiting fetch
    wait_n = 2;
    tick();
    chk("r_pcf208", PCF, 32'h208);
    reset = 1'b0;
    tick();
    chk("r_pcf0",   PCF, 32'h0);
    chk("r_req0",   32'(ImemReq), 32'h0);
    chk("r_vld0",   32'(ValidD), 32'h0);
    chk("r_pc8",    PCPlus8D, 32'h8);
    reset = 1'b1;
    tick();
    chk("r_req1",   32'(ImemReq), 32'h1);
    chk("r_addr0",  ImemAddr, 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
